// File: rtl/adder_2_inputs_arbiter.sv
// Round-robin scheduler sharing one combinational adder among NUM_REQ requesters.
// Serialises operand pairs onto the adder, returns tagged results and flags adder mismatches.
module adder_2_inputs_arbiter #(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         adder_a,
   output logic [WIDTH-1:0]         adder_b,
   input  logic [WIDTH-1:0]         adder_result,
   input  logic                     adder_carry_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_result,
   output logic                     rsp_carry_out,
   output logic                     busy,
   output logic                     add_error
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_gnt_id;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [WIDTH-1:0]  r_rsp_result;
   logic              r_rsp_carry;
   logic              r_add_error;

   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic [WIDTH-1:0]  w_win_a;
   logic [WIDTH-1:0]  w_win_b;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [WIDTH:0]    w_sum;

   // Winner: first valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_win_a  = '0;
      w_win_b  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(r_rr_ptr) + k) % NUM_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found  = 1'b1;
            w_winner = ID_W'(idx);
            w_win_a  = req_a[idx*WIDTH +: WIDTH];
            w_win_b  = req_b[idx*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_req_ready  = '0;
      case (r_state)
         S_IDLE: begin
            // Gated by rst_n so no grant is shown while reset is asserted.
            if (w_found && rst_n) begin
               w_req_ready[w_winner] = 1'b1;
               w_next_state          = S_ADD;
            end
         end
         S_ADD:   w_next_state = S_RESP;
         S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_sum = {1'b0, r_op_a} + {1'b0, r_op_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_gnt_id     <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_carry  <= 1'b0;
         r_add_error  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_op_a   <= w_win_a;
                  r_op_b   <= w_win_b;
                  r_gnt_id <= w_winner;
               end
            end
            S_ADD: begin
               r_rsp_result <= adder_result;
               r_rsp_carry  <= adder_carry_out;
               r_rsp_id     <= r_gnt_id;
               r_rsp_valid  <= 1'b1;
               if ({adder_carry_out, adder_result} != w_sum)
                  r_add_error <= 1'b1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rr_ptr    <= (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready     = w_req_ready;
   assign adder_a       = r_op_a;
   assign adder_b       = r_op_b;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_id        = r_rsp_id;
   assign rsp_result    = r_rsp_result;
   assign rsp_carry_out = r_rsp_carry;
   assign busy          = (r_state != S_IDLE);
   assign add_error     = r_add_error;

endmodule

// File: tb/tb_adder_2_inputs_arbiter.sv
// Directed bench for adder_2_inputs_arbiter with a behavioural adder that can inject a fault.
module tb_adder_2_inputs_arbiter;

   localparam int WIDTH   = 4;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         adder_a;
   logic [WIDTH-1:0]         adder_b;
   logic [WIDTH-1:0]         adder_result;
   logic                     adder_carry_out;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   logic                     rsp_carry_out;
   logic                     busy;
   logic                     add_error;
   logic                     fault_en;

   int n_tests = 0;
   int n_fail  = 0;

   adder_2_inputs_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_a           (req_a),
      .req_b           (req_b),
      .req_ready       (req_ready),
      .adder_a         (adder_a),
      .adder_b         (adder_b),
      .adder_result    (adder_result),
      .adder_carry_out (adder_carry_out),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_result      (rsp_result),
      .rsp_carry_out   (rsp_carry_out),
      .busy            (busy),
      .add_error       (add_error)
   );

   always #5 clk = ~clk;

   // Behavioural adder; returns 0 for 3+4 when fault_en is set.
   always_comb begin
      logic [WIDTH:0] s;
      s = {1'b0, adder_a} + {1'b0, adder_b};
      {adder_carry_out, adder_result} = s;
      if (fault_en && adder_a == 4'd3 && adder_b == 4'd4) adder_result = '0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; fault_en = 1'b0;
      #12;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      n_tests++; if ({adder_a, adder_b} !== 8'h00) begin n_fail++; $display("FAIL reset_adder_ops got %h exp 00", {adder_a, adder_b}); end
      n_tests++; if ({rsp_id, rsp_result, rsp_carry_out, add_error} !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_fields got %h exp 00", {rsp_id, rsp_result, rsp_carry_out, add_error}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      set_req(0, 4'd7, 4'd7);
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      n_tests++; if (req_ready !== 4'b0000 || busy !== 1'b1 || adder_a !== 4'd7) begin n_fail++; $display("FAIL single_add_state got ready=%b busy=%b a=%0d exp 0000/1/7", req_ready, busy, adder_a); end
      tick();
      n_tests++; if ({rsp_valid, rsp_id, rsp_carry_out, rsp_result} !== {1'b1, 2'd0, 1'b0, 4'd14}) begin n_fail++; $display("FAIL single_rsp got v=%b id=%0d c=%b r=%0d exp 1/0/0/14", rsp_valid, rsp_id, rsp_carry_out, rsp_result); end
      tick();
      n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done got v=%b busy=%b exp 0/0", rsp_valid, busy); end
   endtask

   task automatic test_overflow();
      logic [3:0] av [2];
      logic [3:0] bv [2];
      logic [3:0] er [2];
      av = '{4'd14, 4'd15}; bv = '{4'd7, 4'd15}; er = '{4'd5, 4'd14};
      for (int n = 0; n < 2; n++) begin
         set_req(2, av[n], bv[n]);
         #1;
         n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL ovf_grant[%0d] got %b exp 0100", n, req_ready); end
         tick();
         req_valid = '0;
         tick();
         n_tests++; if ({rsp_valid, rsp_id, rsp_carry_out, rsp_result} !== {1'b1, 2'd2, 1'b1, er[n]}) begin n_fail++; $display("FAIL ovf_rsp[%0d] got v=%b id=%0d c=%b r=%0d exp 1/2/1/%0d", n, rsp_valid, rsp_id, rsp_carry_out, rsp_result, er[n]); end
         tick();
      end
      n_tests++; if (add_error !== 1'b0) begin n_fail++; $display("FAIL ovf_add_error got %b exp 0", add_error); end
   endtask

   task automatic test_round_robin();
      int order [5];
      logic [WIDTH:0] exp_sum;
      order = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; #2; rst_n = 1'b1;
      tick();
      rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 3), 4'(2 * i + 5));
      for (int n = 0; n < 5; n++) begin
         #1;
         n_tests++; if (req_ready !== 4'(1 << order[n])) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", n, req_ready, 4'(1 << order[n])); end
         tick();
         tick();
         exp_sum = 5'(order[n] + 3) + 5'(2 * order[n] + 5);
         n_tests++; if ({rsp_valid, rsp_id, rsp_carry_out, rsp_result} !== {1'b1, 2'(order[n]), exp_sum}) begin n_fail++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d c=%b r=%0d exp id %0d sum %0d", n, rsp_valid, rsp_id, rsp_carry_out, rsp_result, order[n], exp_sum); end
         tick();
      end
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_grant1 got %b exp 0010", req_ready); end
      tick();
      req_valid = 4'b1001;
      tick(); tick();
      n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_3_before_0 got %b exp 1000", req_ready); end
      tick();
      req_valid = 4'b0001;
      tick(); tick();
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_then_0 got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      tick(); tick();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(0, 4'd5, 4'd6);
      tick();
      req_valid = '0;
      set_req(1, 4'd2, 4'd3);
      tick();
      for (int n = 0; n < 5; n++) begin
         n_tests++; if ({rsp_valid, rsp_id, rsp_carry_out, rsp_result, req_ready, busy} !== {1'b1, 2'd0, 1'b0, 4'd11, 4'b0000, 1'b1}) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%0d c=%b r=%0d rdy=%b busy=%b exp 1/0/0/11/0000/1", n, rsp_valid, rsp_id, rsp_carry_out, rsp_result, req_ready, busy); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp 0/0010", rsp_valid, req_ready); end
      tick();
      req_valid = '0;
      tick();
      n_tests++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 4'd5}) begin n_fail++; $display("FAIL bp_rsp1 got v=%b id=%0d r=%0d exp 1/1/5", rsp_valid, rsp_id, rsp_result); end
      tick();
   endtask

   task automatic test_fault();
      n_tests++; if (add_error !== 1'b0) begin n_fail++; $display("FAIL fault_pre got %b exp 0", add_error); end
      fault_en = 1'b1;
      set_req(3, 4'd3, 4'd4);
      tick();
      req_valid = '0;
      tick();
      n_tests++; if (add_error !== 1'b1 || rsp_result !== 4'd0 || rsp_id !== 2'd3) begin n_fail++; $display("FAIL fault_detect got err=%b r=%0d id=%0d exp 1/0/3", add_error, rsp_result, rsp_id); end
      tick();
      set_req(0, 4'd1, 4'd1);
      tick();
      req_valid = '0;
      tick();
      n_tests++; if (add_error !== 1'b1 || rsp_result !== 4'd2) begin n_fail++; $display("FAIL fault_sticky got err=%b r=%0d exp 1/2", add_error, rsp_result); end
      tick();
      fault_en = 1'b0;
   endtask

   task automatic test_reset_midop();
      set_req(0, 4'd9, 4'd5);
      set_req(2, 4'd1, 4'd2);
      #1;
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL midop_grant got %b exp 0100", req_ready); end
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if ({busy, rsp_valid, add_error, req_ready, adder_a, adder_b} !== 15'd0) begin n_fail++; $display("FAIL midop_async got busy=%b v=%b err=%b rdy=%b a=%0d b=%0d exp all 0", busy, rsp_valid, add_error, req_ready, adder_a, adder_b); end
      #2;
      rst_n = 1'b1;
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_regrant got %b exp 0001", req_ready); end
      tick();
      req_valid = '0;
      tick();
      n_tests++; if ({rsp_valid, rsp_id, rsp_carry_out, rsp_result} !== {1'b1, 2'd0, 1'b0, 4'd14}) begin n_fail++; $display("FAIL midop_rsp got v=%b id=%0d c=%b r=%0d exp 1/0/0/14", rsp_valid, rsp_id, rsp_carry_out, rsp_result); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_round_robin();
      test_backpressure();
      test_fault();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
